cordic_hyperbolic_seq: RTL and testbench

- Iterative hyperbolic CORDIC engine, one micro-rotation per clock.
- It is the reader of the combinational atanh constant ROM. It drives the ROM index each cycle and consumes the returned angle in the same cycle.
- It supports rotation mode (cosh/sinh) and vectoring mode (atanh, magnitude). It sits behind the peripheral register interface as the hyperbolic datapath.

---
 rtl/cordic_hyperbolic_seq.sv | 158 +++++++++++++++
 tb/tb_cordic_hyperbolic_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_hyperbolic_seq.sv
// Iterative hyperbolic CORDIC, one micro-rotation per clock, rotation or vectoring mode.
// Define CORDIC_HYP_GAIN_COMP_EN to add a 1/Kh gain-compensation state before results are published.
module cordic_hyperbolic_seq #(
   parameter int FIXED_WIDTH = 16,
   parameter int ITERATIONS  = 9
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic                                  mode,
   input  logic signed [FIXED_WIDTH-1:0]         x_in,
   input  logic signed [FIXED_WIDTH-1:0]         y_in,
   input  logic signed [FIXED_WIDTH-1:0]         z_in,
   output logic        [$clog2(ITERATIONS)-1:0]  rom_idx,
   input  logic signed [FIXED_WIDTH-1:0]         rom_angle,
   output logic                                  busy,
   output logic                                  done,
   output logic signed [FIXED_WIDTH-1:0]         x_out,
   output logic signed [FIXED_WIDTH-1:0]         y_out,
   output logic signed [FIXED_WIDTH-1:0]         z_out
);

   localparam int IW = $clog2(ITERATIONS);

`ifdef CORDIC_HYP_GAIN_COMP_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMP, S_FIN} state_t;

   // Shift-add approximation of 1/Kh (about 1.20752).
   function automatic logic signed [FIXED_WIDTH-1:0] gain_comp(input logic signed [FIXED_WIDTH-1:0] v);
      return v + (v >>> 2) - (v >>> 5) - (v >>> 7) - (v >>> 8) + (v >>> 11);
   endfunction
`else
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
`endif

   state_t                        state_q, state_d;
   logic [IW-1:0]                 i_q, i_d;
   logic                          rep_q, rep_d;
   logic                          mode_q, mode_d;
   logic signed [FIXED_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic signed [FIXED_WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;

   logic signed [FIXED_WIDTH-1:0] step_x, step_y, step_z;
   logic                          d_pos;
   logic                          need_rep;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= IW'(1);
         rep_q   <= 1'b0;
         mode_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         x_out_q <= '0;
         y_out_q <= '0;
         z_out_q <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         rep_q   <= rep_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         x_out_q <= x_out_d;
         y_out_q <= y_out_d;
         z_out_q <= z_out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      rep_d   = rep_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      x_out_d = x_out_q;
      y_out_d = y_out_q;
      z_out_d = z_out_q;

      // d=+1 drives the controlled variable (z or y) toward zero.
      d_pos    = mode_q ? y_q[FIXED_WIDTH-1] : ~z_q[FIXED_WIDTH-1];
      need_rep = (int'(i_q) == 4) || ((ITERATIONS > 13) && (int'(i_q) == 13));
      if (d_pos) begin
         step_x = x_q + (y_q >>> i_q);
         step_y = y_q + (x_q >>> i_q);
         step_z = z_q - rom_angle;
      end else begin
         step_x = x_q - (y_q >>> i_q);
         step_y = y_q - (x_q >>> i_q);
         step_z = z_q + rom_angle;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d     = x_in;
               y_d     = y_in;
               z_d     = z_in;
               mode_d  = mode;
               i_d     = IW'(1);
               rep_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            x_d = step_x;
            y_d = step_y;
            z_d = step_z;
            if (need_rep && !rep_q) begin
               rep_d = 1'b1;
            end else begin
               rep_d = 1'b0;
               i_d   = i_q + IW'(1);
               if (i_q == IW'(ITERATIONS-1)) begin
`ifdef CORDIC_HYP_GAIN_COMP_EN
                  state_d = S_COMP;
`else
                  x_out_d = step_x;
                  y_out_d = step_y;
                  z_out_d = step_z;
                  state_d = S_FIN;
`endif
               end
            end
         end
`ifdef CORDIC_HYP_GAIN_COMP_EN
         S_COMP: begin
            x_d     = gain_comp(x_q);
            y_d     = gain_comp(y_q);
            x_out_d = gain_comp(x_q);
            y_out_d = gain_comp(y_q);
            z_out_d = z_q;
            state_d = S_FIN;
         end
`endif
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Results are registered on entry to FIN so they are valid alongside done.
   assign rom_idx = (state_q == S_RUN) ? i_q : IW'(1);
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_FIN);
   assign x_out   = x_out_q;
   assign y_out   = y_out_q;
   assign z_out   = z_out_q;

endmodule

// File: tb/tb_cordic_hyperbolic_seq.sv
// Bench for cordic_hyperbolic_seq: directed steps, scoreboard of model results popped on done.
module tb_cordic_hyperbolic_seq;

   localparam int W    = 16;
   localparam int ITER = 9;
`ifdef CORDIC_HYP_GAIN_COMP_EN
   localparam int LAT  = 11;
`else
   localparam int LAT  = 10;
`endif

   typedef struct {
      logic signed [W-1:0] x;
      logic signed [W-1:0] y;
      logic signed [W-1:0] z;
   } res_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                mode;
   logic signed [W-1:0] x_in, y_in, z_in;
   logic        [3:0]   rom_idx;
   logic signed [W-1:0] rom_angle;
   logic                busy, done;
   logic signed [W-1:0] x_out, y_out, z_out;

   int   checks = 0;
   int   errors = 0;
   res_t sb_q[$];
   int   idx_seq[$];

   always #5 clk = ~clk;

   cordic_hyperbolic_seq #(.FIXED_WIDTH(W), .ITERATIONS(ITER)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .rom_idx(rom_idx), .rom_angle(rom_angle),
      .busy(busy), .done(done),
      .x_out(x_out), .y_out(y_out), .z_out(z_out)
   );

   // atanh(2^-i) in Q2.14, rounded to nearest.
   function automatic logic signed [W-1:0] atanh_rom(input logic [3:0] idx);
      case (idx)
         4'd1:    return 16'sd9000;
         4'd2:    return 16'sd4185;
         4'd3:    return 16'sd2059;
         4'd4:    return 16'sd1025;
         4'd5:    return 16'sd512;
         4'd6:    return 16'sd256;
         4'd7:    return 16'sd128;
         4'd8:    return 16'sd64;
         default: return 16'sd0;
      endcase
   endfunction

   assign rom_angle = atanh_rom(rom_idx);

   function automatic longint wrap16(input longint v);
      logic signed [W-1:0] t;
      t = v[W-1:0];
      return longint'(t);
   endfunction

   function automatic res_t model(input bit m, input logic signed [W-1:0] x0, y0, z0);
      longint x, y, z, xn, yn;
      longint d;
      int     passes;
      res_t   r;
      x = longint'(x0);
      y = longint'(y0);
      z = longint'(z0);
      for (int i = 1; i < ITER; i++) begin
         passes = (i == 4 || (i == 13 && ITER > 13)) ? 2 : 1;
         for (int p = 0; p < passes; p++) begin
            if (m == 1'b0) d = (z >= 0) ? 1 : -1;
            else           d = (y < 0)  ? 1 : -1;
            xn = x + d * (x >= 0 ? 0 : 0) + d * (y >>> i);
            yn = y + d * (x >>> i);
            z  = wrap16(z - d * longint'(atanh_rom(4'(i))));
            x  = wrap16(xn);
            y  = wrap16(yn);
         end
      end
`ifdef CORDIC_HYP_GAIN_COMP_EN
      x = wrap16(x + (x >>> 2) - (x >>> 5) - (x >>> 7) - (x >>> 8) + (x >>> 11));
      y = wrap16(y + (y >>> 2) - (y >>> 5) - (y >>> 7) - (y >>> 8) + (y >>> 11));
`endif
      r.x = 16'(x);
      r.y = 16'(y);
      r.z = 16'(z);
      return r;
   endfunction

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Nine steps leave up to ~30 LSB of residual error, so reference-value checks use a 48 LSB window.
   task automatic check_near(input string tag, input logic signed [63:0] obs, input logic signed [63:0] target);
      checks++;
      assert ((obs - target) <= 48 && (target - obs) <= 48) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d+/-48", tag, obs, target);
      end
   endtask

   always @(negedge clk) begin
      res_t e;
      if (done === 1'b1) begin
         check("sb_entry_present", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("x_out", x_out, e.x);
            check("y_out", y_out, e.y);
            check("z_out", z_out, e.z);
         end
      end
   end

   // Issues one operation and traces rom_idx/busy/done; optionally fires ignored start pulses.
   task automatic run_op(input bit m, input logic signed [W-1:0] xi, yi, zi, input bit inject);
      int done_cnt = 0;
      int done_at  = -1;
      int busy_cnt = 0;
      @(negedge clk);
      mode  = m;
      x_in  = xi;
      y_in  = yi;
      z_in  = zi;
      start = 1'b1;
      sb_q.push_back(model(m, xi, yi, zi));
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         if (k <= idx_seq.size()) check($sformatf("rom_idx_step%0d", k), rom_idx, idx_seq[k-1]);
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         if (k == LAT + 1) check("rom_idx_idle", rom_idx, 1);
         start = 1'b0;
         if (inject && (k == 3 || k == 9 || k == LAT)) begin
            start = 1'b1;
            mode  = ~m;
            x_in  = 16'($urandom);
            y_in  = 16'($urandom);
            z_in  = 16'($urandom);
         end
      end
      start = 1'b0;
      check("done_count", done_cnt, 1);
      check("done_cycle", done_at, LAT);
      check("busy_cycles", busy_cnt, LAT);
      $display("op mode=%0d x_in=%0d y_in=%0d z_in=%0d -> x_out=%0d y_out=%0d z_out=%0d done_at=%0d",
               m, xi, yi, zi, x_out, y_out, z_out, done_at);
   endtask

   initial begin
      res_t held;
      int   extra_done;

      for (int i = 1; i < ITER; i++) begin
         idx_seq.push_back(i);
         if (i == 4 || (i == 13 && ITER > 13)) idx_seq.push_back(i);
      end

      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      x_in  = '0;
      y_in  = '0;
      z_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rom_idx", rom_idx, 1);
      check("rst_x_out", x_out, 0);
      check("rst_y_out", y_out, 0);
      check("rst_z_out", z_out, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);

`ifndef CORDIC_HYP_GAIN_COMP_EN
      run_op(1'b0, 16'sh4D48, 16'sh0000, 16'sh2000, 1'b0);
      check_near("rot_cosh", x_out, 18475);
      check_near("rot_sinh", y_out, 8538);
      check_near("rot_zres", z_out, 0);
`else
      run_op(1'b0, 16'sh4000, 16'sh0000, 16'sh2000, 1'b0);
      check_near("comp_cosh", x_out, 18475);
      check_near("comp_sinh", y_out, 8538);
`endif

      run_op(1'b1, 16'sh4000, 16'sh2000, 16'sh0000, 1'b0);
      check_near("vec_atanh", z_out, 9000);
      check_near("vec_yres", y_out, 0);

      // Extra start requests mid-run and in the final cycle must be dropped.
      held = model(1'b0, 16'sh3000, 16'sh0800, -16'sh1000);
      run_op(1'b0, 16'sh3000, 16'sh0800, -16'sh1000, 1'b1);
      extra_done = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done === 1'b1) extra_done++;
      end
      check("no_queued_done", extra_done, 0);
      check("hold_x_out", x_out, held.x);
      check("hold_y_out", y_out, held.y);
      check("hold_z_out", z_out, held.z);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      mode  = 1'b0;
      x_in  = 16'sh2000;
      y_in  = 16'sh1000;
      z_in  = 16'sh1000;
      start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_rom_idx", rom_idx, 1);
      check("midrst_x_out", x_out, 0);
      check("midrst_y_out", y_out, 0);
      check("midrst_z_out", z_out, 0);
      @(negedge clk);
      rst = 1'b0;
      run_op(1'b1, 16'sh4000, 16'sh2000, 16'sh0000, 1'b0);
      check_near("post_rst_atanh", z_out, 9000);

      for (int n = 0; n < 4; n++) begin
         run_op(1'(n), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      end

      repeat (2) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
